// File: rtl/simmem_delay_scheduler_if.sv
// Request/release handshake bundle for the simulated-memory delay scheduler.
// The scheduler connects to the slave modport; the request source and release sink use master.
interface simmem_delay_scheduler_if #(
  parameter int unsigned NumSlots     = 8,
  parameter int unsigned IDWidth      = 4,
  parameter int unsigned CounterWidth = 8
);
  localparam int unsigned SlotWidth = $clog2(NumSlots);

  logic                    addr_valid_i;
  logic                    addr_ready_o;
  logic [IDWidth-1:0]      addr_id_i;
  logic [CounterWidth-1:0] addr_delay_i;
  logic                    release_valid_o;
  logic                    release_ready_i;
  logic [IDWidth-1:0]      release_id_o;
  logic [SlotWidth-1:0]    release_slot_o;

  modport master (
    output addr_valid_i, addr_id_i, addr_delay_i, release_ready_i,
    input  addr_ready_o, release_valid_o, release_id_o, release_slot_o
  );

  modport slave (
    input  addr_valid_i, addr_id_i, addr_delay_i, release_ready_i,
    output addr_ready_o, release_valid_o, release_id_o, release_slot_o
  );
endinterface

// File: rtl/simmem_delay_scheduler.sv
// Per-request delay scheduler: slots count down, then are released oldest-first with same-ID ordering.
// Optional macro SIMMEM_SCHED_STALL_STATS_EN enables the saturating release-backpressure counter.
module simmem_delay_scheduler #(
  parameter int unsigned NumSlots     = 8,
  parameter int unsigned IDWidth      = 4,
  parameter int unsigned CounterWidth = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  simmem_delay_scheduler_if.slave         bus,
  output logic [$clog2(NumSlots+1)-1:0]   num_pending_o,
  output logic [31:0]                     stall_cnt_o
);
  localparam int unsigned SlotWidth = $clog2(NumSlots);
  localparam int unsigned PendWidth = $clog2(NumSlots + 1);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_COUNTING = 2'd1,
    SLOT_ELIGIBLE = 2'd2
  } slot_state_e;

  slot_state_e             state_q [NumSlots];
  slot_state_e             state_d [NumSlots];
  logic [CounterWidth-1:0] cnt_q   [NumSlots];
  logic [CounterWidth-1:0] cnt_d   [NumSlots];
  logic [IDWidth-1:0]      id_q    [NumSlots];
  logic [IDWidth-1:0]      id_d    [NumSlots];
  logic [NumSlots-1:0]     older_q [NumSlots];
  logic [NumSlots-1:0]     older_d [NumSlots];

  logic [NumSlots-1:0]  occupied_s;
  logic [NumSlots-1:0]  eligible_s;
  logic [NumSlots-1:0]  candidate_s;
  logic [NumSlots-1:0]  grant_s;
  logic [SlotWidth-1:0] grant_idx_s;
  logic [SlotWidth-1:0] acc_idx_s;
  logic [PendWidth-1:0] pending_s;
  logic                 addr_ready_s;
  logic                 release_valid_s;
  logic                 accept_s;
  logic                 release_fire_s;

  // A candidate has no older occupied slot of the same ID; the grant is the candidate with no older candidate.
  always_comb begin
    occupied_s   = '0;
    eligible_s   = '0;
    candidate_s  = '0;
    grant_s      = '0;
    grant_idx_s  = '0;
    acc_idx_s    = '0;
    pending_s    = '0;
    for (int i = 0; i < NumSlots; i++) begin
      occupied_s[i] = (state_q[i] != SLOT_FREE);
      eligible_s[i] = (state_q[i] == SLOT_ELIGIBLE);
      pending_s     = pending_s + PendWidth'(occupied_s[i]);
    end
    for (int i = 0; i < NumSlots; i++) begin
      candidate_s[i] = eligible_s[i];
      for (int j = 0; j < NumSlots; j++) begin
        if (j != i && occupied_s[j] && (id_q[j] == id_q[i]) && older_q[j][i]) begin
          candidate_s[i] = 1'b0;
        end else begin
          candidate_s[i] = candidate_s[i];
        end
      end
    end
    for (int i = 0; i < NumSlots; i++) begin
      grant_s[i] = candidate_s[i];
      for (int j = 0; j < NumSlots; j++) begin
        if (j != i && candidate_s[j] && older_q[j][i]) begin
          grant_s[i] = 1'b0;
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
    for (int i = 0; i < NumSlots; i++) begin
      if (grant_s[i]) begin
        grant_idx_s = SlotWidth'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!occupied_s[i]) begin
        acc_idx_s = SlotWidth'(i);
      end else begin
        acc_idx_s = acc_idx_s;
      end
    end
    addr_ready_s    = ~(&occupied_s);
    release_valid_s = |candidate_s;
    accept_s        = bus.addr_valid_i & addr_ready_s;
    release_fire_s  = release_valid_s & bus.release_ready_i;
  end

  assign bus.addr_ready_o    = addr_ready_s;
  assign bus.release_valid_o = release_valid_s;
  assign bus.release_id_o    = release_valid_s ? id_q[grant_idx_s] : {IDWidth{1'b0}};
  assign bus.release_slot_o  = grant_idx_s;
  assign num_pending_o       = pending_s;

  // Per-slot FSM, countdown and age-matrix update for the accept/release of this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    older_d = older_q;
    for (int i = 0; i < NumSlots; i++) begin
      case (state_q[i])
        SLOT_FREE: begin
          if (accept_s && (acc_idx_s == SlotWidth'(i))) begin
            id_d[i]  = bus.addr_id_i;
            cnt_d[i] = bus.addr_delay_i;
            if (bus.addr_delay_i == {CounterWidth{1'b0}}) begin
              state_d[i] = SLOT_ELIGIBLE;
            end else begin
              state_d[i] = SLOT_COUNTING;
            end
          end else begin
            state_d[i] = SLOT_FREE;
          end
        end
        SLOT_COUNTING: begin
          if (cnt_q[i] <= {{(CounterWidth-1){1'b0}}, 1'b1}) begin
            state_d[i] = SLOT_ELIGIBLE;
            cnt_d[i]   = {CounterWidth{1'b0}};
          end else begin
            cnt_d[i]   = cnt_q[i] - {{(CounterWidth-1){1'b0}}, 1'b1};
          end
        end
        SLOT_ELIGIBLE: begin
          if (release_fire_s && (grant_idx_s == SlotWidth'(i))) begin
            state_d[i] = SLOT_FREE;
          end else begin
            state_d[i] = SLOT_ELIGIBLE;
          end
        end
        default: begin
          state_d[i] = SLOT_FREE;
          cnt_d[i]   = {CounterWidth{1'b0}};
        end
      endcase
    end
    // A newly accepted slot is younger than everything currently occupied.
    if (accept_s) begin
      for (int j = 0; j < NumSlots; j++) begin
        older_d[j][acc_idx_s] = occupied_s[j];
      end
      older_d[acc_idx_s] = {NumSlots{1'b0}};
    end else begin
      older_d = older_d;
    end
  end

  // Slot state registers; reset discards every slot, including any handshake in the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= SLOT_FREE;
        cnt_q[i]   <= {CounterWidth{1'b0}};
        id_q[i]    <= {IDWidth{1'b0}};
        older_q[i] <= {NumSlots{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      older_q <= older_d;
    end
  end

`ifdef SIMMEM_SCHED_STALL_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  // Saturating count of cycles where a grant waits on the downstream bank.
  always_comb begin
    if (release_valid_s && !bus.release_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_simmem_delay_scheduler.sv
// Directed scoreboard bench for simmem_delay_scheduler: expected releases are queued at stimulus
// time and compared on each release handshake; define SIMMEM_SCHED_STALL_STATS_EN to match the DUT build.
module tb_simmem_delay_scheduler;
  localparam int unsigned NS  = 8;
  localparam int unsigned IDW = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned PW  = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] num_pending;
  logic [31:0]   stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int k;
  int vcnt;
  logic [IDW-1:0] exp_id_q [$];
  logic [2:0]     exp_slot_q [$];
  logic [31:0]    stall_exp;

  simmem_delay_scheduler_if #(.NumSlots(NS), .IDWidth(IDW), .CounterWidth(CW)) bus ();

  simmem_delay_scheduler #(.NumSlots(NS), .IDWidth(IDW), .CounterWidth(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .num_pending_o (num_pending),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [2:0] slot);
    exp_id_q.push_back(id);
    exp_slot_q.push_back(slot);
  endtask

  // One clock: score any release handshake at mid-cycle, then step to just after the edge.
  task automatic tick();
    logic [IDW-1:0] eid;
    logic [2:0]     eslot;
    @(negedge clk);
    if (!rst && bus.release_valid_o && bus.release_ready_i) begin
      check("sb_expected_avail", 32'(exp_id_q.size() > 0), 32'd1);
      if (exp_id_q.size() > 0) begin
        eid   = exp_id_q.pop_front();
        eslot = exp_slot_q.pop_front();
        check("sb_release_id", 32'(bus.release_id_o), 32'(eid));
        check("sb_release_slot", 32'(bus.release_slot_o), 32'(eslot));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.addr_valid_i    = 1'b0;
    bus.addr_id_i       = '0;
    bus.addr_delay_i    = '0;
    bus.release_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_addr_ready", 32'(bus.addr_ready_o), 32'd1);
    check("rst_release_valid", 32'(bus.release_valid_o), 32'd0);
    check("rst_release_id", 32'(bus.release_id_o), 32'd0);
    check("rst_release_slot", 32'(bus.release_slot_o), 32'd0);
    check("rst_num_pending", 32'(num_pending), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);

    // Single request id=2 delay=5: first valid 5 ticks after the accepting edge.
    bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'd2; bus.addr_delay_i = 8'd5;
    push(4'd2, 3'd0);
    tick();
    bus.addr_valid_i = 1'b0;
    k = 0;
    while (!bus.release_valid_o && k < 40) begin tick(); k++; end
    check("t1_latency", 32'(k), 32'd5);
    check("t1_release_id", 32'(bus.release_id_o), 32'd2);
    tick();
    check("t1_pending_after", 32'(num_pending), 32'd0);

    // Same ID: the zero-delay request waits for the older one, grants back-to-back.
    bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'd3; bus.addr_delay_i = 8'd10;
    push(4'd3, 3'd0);
    tick();
    bus.addr_delay_i = 8'd0;
    push(4'd3, 3'd1);
    tick();
    bus.addr_valid_i = 1'b0;
    check("t2_younger_held", 32'(bus.release_valid_o), 32'd0);
    k = 0;
    while (!bus.release_valid_o && k < 40) begin tick(); k++; end
    check("t2_latency", 32'(k), 32'd9);
    check("t2_first_slot", 32'(bus.release_slot_o), 32'd0);
    tick();
    check("t2_back_to_back_valid", 32'(bus.release_valid_o), 32'd1);
    check("t2_second_slot", 32'(bus.release_slot_o), 32'd1);
    tick();
    check("t2_pending_after", 32'(num_pending), 32'd0);

    // Different IDs are independent: id=4 overtakes id=1.
    bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'd1; bus.addr_delay_i = 8'd8;
    push(4'd4, 3'd1);
    push(4'd1, 3'd0);
    tick();
    bus.addr_id_i = 4'd4; bus.addr_delay_i = 8'd0;
    tick();
    bus.addr_valid_i = 1'b0;
    check("t3_fast_valid", 32'(bus.release_valid_o), 32'd1);
    check("t3_fast_id", 32'(bus.release_id_o), 32'd4);
    tick();
    k = 0;
    while (!bus.release_valid_o && k < 40) begin tick(); k++; end
    check("t3_slow_latency", 32'(k), 32'd6);
    check("t3_slow_id", 32'(bus.release_id_o), 32'd1);
    tick();
    check("t3_pending_after", 32'(num_pending), 32'd0);

    // Fill all slots, then hold a 9th request until the first release frees slot 0.
    for (int i = 0; i < 8; i++) begin
      bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'(i); bus.addr_delay_i = 8'd20;
      push(4'(i), 3'(i));
      tick();
    end
    check("t4_full_ready", 32'(bus.addr_ready_o), 32'd0);
    check("t4_full_pending", 32'(num_pending), 32'd8);
    bus.addr_id_i = 4'd9; bus.addr_delay_i = 8'd0;
    push(4'd9, 3'd0);
    k = 0;
    while (!bus.addr_ready_o && k < 40) begin tick(); k++; end
    check("t4_ready_wait", 32'(k), 32'd14);
    check("t4_pending_at_ready", 32'(num_pending), 32'd7);
    tick();
    bus.addr_valid_i = 1'b0;
    check("t4_accept_and_release", 32'(num_pending), 32'd7);
    k = 0;
    while (num_pending != '0 && k < 40) begin tick(); k++; end
    check("t4_drained", 32'(num_pending), 32'd0);

    // Backpressure: grant must stay on the older eligible slot while ready is low.
    bus.release_ready_i = 1'b0;
    bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'd5; bus.addr_delay_i = 8'd1;
    push(4'd5, 3'd0);
    tick();
    bus.addr_id_i = 4'd6; bus.addr_delay_i = 8'd0;
    push(4'd6, 3'd1);
    tick();
    bus.addr_valid_i = 1'b0;
    check("t5_grant_valid", 32'(bus.release_valid_o), 32'd1);
    check("t5_stall_start", stall_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_hold_slot", 32'(bus.release_slot_o), 32'd0);
      check("t5_hold_id", 32'(bus.release_id_o), 32'd5);
    end
`ifdef SIMMEM_SCHED_STALL_STATS_EN
    stall_exp = 32'd4;
`else
    stall_exp = 32'd0;
`endif
    check("t5_stall_cnt", stall_cnt, stall_exp);
    bus.release_ready_i = 1'b1;
    tick();
    check("t5_second_slot", 32'(bus.release_slot_o), 32'd1);
    check("t5_second_id", 32'(bus.release_id_o), 32'd6);
    tick();
    check("t5_pending_after", 32'(num_pending), 32'd0);

    // Mid-operation reset with a concurrent handshake discards everything.
    for (int i = 0; i < 5; i++) begin
      bus.addr_valid_i = 1'b1; bus.addr_id_i = 4'(i); bus.addr_delay_i = 8'd50;
      tick();
    end
    check("t6_pending_before", 32'(num_pending), 32'd5);
    rst = 1'b1;
    bus.addr_id_i = 4'd7; bus.addr_delay_i = 8'd0;
    tick();
    rst = 1'b0;
    bus.addr_valid_i = 1'b0;
    check("t6_pending_after_rst", 32'(num_pending), 32'd0);
    check("t6_valid_after_rst", 32'(bus.release_valid_o), 32'd0);
    check("t6_ready_after_rst", 32'(bus.addr_ready_o), 32'd1);
    check("t6_stall_after_rst", stall_cnt, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.release_valid_o) vcnt++;
      tick();
    end
    check("t6_no_ghost_release", 32'(vcnt), 32'd0);
    check("sb_queue_empty", 32'(exp_id_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
